fetch_unit: RTL and testbench

- Instruction-fetch stage of the MIPS core.
- Owns the program counter and drives the word address of the 64-word instruction memory.
- Captures the returned instruction into an IF/ID pipeline register for decode and register-file read.
- Supports stall, branch/jump redirect with flush, an out-of-range halt state, and a count of delivered fetches.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/adder32.sv | 8 +
 rtl/fetch_unit_if_id_reg.sv | 34 +++
 rtl/fetch_unit.sv | 77 +++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 6 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    typedef enum logic {FS_RUN, FS_HALT} fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
interface fetch_unit_if #(parameter int IMEM_AW = 6);
    logic               stall;
    logic               redirect;
    logic [31:0]        redirect_pc;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rd;
    logic [31:0]        if_id_instr;
    logic [31:0]        if_id_pc;
    logic [31:0]        if_id_pcplus4;
    logic               if_id_valid;
    logic               fault;
    logic [31:0]        fetch_count;

    modport master (
        input  stall, redirect, redirect_pc, imem_rd,
        output imem_addr, if_id_instr, if_id_pc, if_id_pcplus4, if_id_valid,
               fault, fetch_count
    );

    modport slave (
        output stall, redirect, redirect_pc, imem_rd,
        input  imem_addr, if_id_instr, if_id_pc, if_id_pcplus4, if_id_valid,
               fault, fetch_count
    );
endinterface

// File: rtl/adder32.sv
// Plain 32-bit adder, carry discarded (wraps modulo 2^32).
module adder32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    assign y = a + b;
endmodule

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register; reset beats flush, flush beats load.
import fetch_pkg::*;

module if_id_reg (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] instr_d,
    input  logic [31:0] pc_d,
    input  logic [31:0] pcplus4_d,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pcplus4,
    output logic        valid
);
    always_ff @(posedge clk) begin
        if (reset) begin
            instr   <= NOP_INSTR;
            pc      <= '0;
            pcplus4 <= '0;
            valid   <= 1'b0;
        end else if (flush) begin
            // A bubble keeps the last PC pair so decode sees a stable address.
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (load) begin
            instr   <= instr_d;
            pc      <= pc_d;
            pcplus4 <= pcplus4_d;
            valid   <= 1'b1;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, range check, HALT on out-of-range PC, IF/ID capture.
//   state   | meaning
//   FS_RUN  | fetching; PC advances unless stalled
//   FS_HALT | PC left the memory range; IF/ID held as bubble until redirect
import fetch_pkg::*;

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 6
) (
    input  logic clk,
    input  logic reset,
    fetch_unit_if.master bus
);
    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt, pc_plus4;
    logic [31:0]  fetch_count;
    logic         in_range;
    logic         load, flush, count_inc;

    adder32 u_pc_add (.a(pc), .b(PC_STEP), .y(pc_plus4));

    assign in_range      = (pc[31:IMEM_AW+2] == '0);
    assign bus.imem_addr = pc[IMEM_AW+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FS_RUN;
            pc          <= RESET_PC;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (count_inc) fetch_count <= fetch_count + 32'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load      = 1'b0;
        flush     = 1'b0;
        count_inc = 1'b0;
        if (bus.redirect) begin
            state_nxt = FS_RUN;
            pc_nxt    = bus.redirect_pc & ~32'h3;
            flush     = 1'b1;
        end else if (state == FS_HALT) begin
            flush = 1'b1;
        end else if (!in_range) begin
            state_nxt = FS_HALT;
            flush     = 1'b1;
        end else if (!bus.stall) begin
            pc_nxt    = pc_plus4;
            load      = 1'b1;
            count_inc = 1'b1;
        end
    end

    if_id_reg u_if_id (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .flush     (flush),
        .instr_d   (bus.imem_rd),
        .pc_d      (pc),
        .pcplus4_d (pc_plus4),
        .instr     (bus.if_id_instr),
        .pc        (bus.if_id_pc),
        .pcplus4   (bus.if_id_pcplus4),
        .valid     (bus.if_id_valid)
    );

    // HALT is the only source of fault, so the state register is the fault flop.
    assign bus.fault       = (state == FS_HALT);
    assign bus.fetch_count = fetch_count;
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed test-plan steps plus random stall/redirect/reset traffic.
module tb_fetch_unit;
    localparam int          AW    = 6;
    localparam logic [31:0] RPC   = 32'h0;
    localparam int          BYTES = 4 * (2 ** AW);

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] p4;
        logic        valid;
        logic        fault;
        logic [31:0] count;
        logic [31:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mem [BYTES/4];
    exp_t        sb_q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    // reference state
    logic [31:0] m_pc, m_instr, m_ipc, m_ip4, m_cnt;
    logic        m_valid, m_halt;

    fetch_unit_if #(.IMEM_AW(AW)) bus ();
    fetch_unit #(.RESET_PC(RPC), .IMEM_AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    assign bus.imem_rd = mem[bus.imem_addr];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout: got running want finished");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // One clock: drive inputs at negedge, advance the model, queue the expected post-edge view.
    task automatic cyc(input logic r, input logic s, input logic d, input logic [31:0] t);
        exp_t e;
        @(negedge clk);
        reset           = r;
        bus.stall       = s;
        bus.redirect    = d;
        bus.redirect_pc = t;
        if (r) begin
            m_pc = RPC; m_halt = 0; m_instr = 0; m_ipc = 0; m_ip4 = 0; m_valid = 0; m_cnt = 0;
        end else if (d) begin
            m_pc = (t / 4) * 4; m_halt = 0; m_valid = 0; m_instr = 0;
        end else if (m_halt) begin
            m_valid = 0; m_instr = 0;
        end else if (m_pc >= BYTES) begin
            m_halt = 1; m_valid = 0; m_instr = 0;
        end else if (!s) begin
            m_instr = mem[m_pc / 4];
            m_ipc   = m_pc;
            m_ip4   = m_pc + 4;
            m_valid = 1;
            m_pc    = m_pc + 4;
            m_cnt   = m_cnt + 1;
        end
        e.instr = m_instr; e.pc = m_ipc; e.p4 = m_ip4; e.valid = m_valid;
        e.fault = m_halt; e.count = m_cnt; e.addr = (m_pc / 4) % (BYTES / 4);
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                cmp("sb_instr", bus.if_id_instr, e.instr);
                cmp("sb_pc", bus.if_id_pc, e.pc);
                cmp("sb_pcplus4", bus.if_id_pcplus4, e.p4);
                cmp("sb_valid", {31'b0, bus.if_id_valid}, {31'b0, e.valid});
                cmp("sb_fault", {31'b0, bus.fault}, {31'b0, e.fault});
                cmp("sb_count", bus.fetch_count, e.count);
                cmp("sb_imem_addr", {26'b0, bus.imem_addr}, e.addr);
            end
        end
    end

    task automatic chk_zero(input string tag);
        cmp({tag, "_instr"}, bus.if_id_instr, 32'h0);
        cmp({tag, "_pc"}, bus.if_id_pc, 32'h0);
        cmp({tag, "_pcplus4"}, bus.if_id_pcplus4, 32'h0);
        cmp({tag, "_valid"}, {31'b0, bus.if_id_valid}, 32'h0);
        cmp({tag, "_fault"}, {31'b0, bus.fault}, 32'h0);
        cmp({tag, "_count"}, bus.fetch_count, 32'h0);
        cmp({tag, "_addr"}, {26'b0, bus.imem_addr}, RPC / 4);
    endtask

    initial begin : stim
        int r;
        logic [31:0] t;
        for (int k = 0; k < BYTES / 4; k++) mem[k] = 32'h1000_0000 + k;
        bus.stall = 0; bus.redirect = 0; bus.redirect_pc = 0;

        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk_zero("reset");

        repeat (3) cyc(0, 0, 0, 0);
        cmp("line_pc", bus.if_id_pc, 32'd8);
        cmp("line_instr", bus.if_id_instr, 32'h1000_0002);
        cmp("line_valid", {31'b0, bus.if_id_valid}, 32'd1);
        cmp("line_count", bus.fetch_count, 32'd3);

        for (int i = 0; i < 2; i++) begin
            cyc(0, 1, 0, 0);
            cmp("stall_pc", bus.if_id_pc, 32'd8);
            cmp("stall_count", bus.fetch_count, 32'd3);
        end
        cyc(0, 0, 0, 0);
        cmp("post_stall_pc", bus.if_id_pc, 32'd12);

        cyc(0, 0, 1, 32'h0000_0043);
        cmp("redir_bubble_valid", {31'b0, bus.if_id_valid}, 32'd0);
        cmp("redir_bubble_instr", bus.if_id_instr, 32'd0);
        cmp("redir_target_addr", {26'b0, bus.imem_addr}, 32'd16);
        cyc(0, 0, 0, 0);
        cmp("redir_pc", bus.if_id_pc, 32'h40);
        cmp("redir_instr", bus.if_id_instr, 32'h1000_0010);

        cyc(0, 1, 1, 32'h0000_0080);
        cmp("redir_stall_valid", {31'b0, bus.if_id_valid}, 32'd0);
        cmp("redir_stall_addr", {26'b0, bus.imem_addr}, 32'd32);
        cyc(0, 0, 0, 0);
        cmp("redir_stall_pc", bus.if_id_pc, 32'h80);

        cyc(0, 0, 1, 32'h0000_00F0);
        repeat (4) cyc(0, 0, 0, 0);
        cmp("edge_last_pc", bus.if_id_pc, 32'hFC);
        cyc(0, 0, 0, 0);
        cmp("halt_fault", {31'b0, bus.fault}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1'($urandom_range(0, 1)), 0, 0);
            cmp("halt_valid", {31'b0, bus.if_id_valid}, 32'd0);
            cmp("halt_fault_hold", {31'b0, bus.fault}, 32'd1);
            cmp("halt_pc_hold", bus.if_id_pc, 32'hFC);
        end
        cyc(0, 0, 1, 32'h0);
        cmp("resume_fault", {31'b0, bus.fault}, 32'd0);
        cyc(0, 0, 0, 0);
        cmp("resume_pc", bus.if_id_pc, 32'h0);
        cmp("resume_instr", bus.if_id_instr, 32'h1000_0000);

        cyc(0, 0, 1, 32'h0000_00FC);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cmp("halt2_fault", {31'b0, bus.fault}, 32'd1);
        cyc(1, 0, 0, 0);
        chk_zero("rst_halt");

        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 1, 1, 32'h44);
        chk_zero("rst_stall");

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      t = $urandom_range(0, BYTES - 1);
            else if (r < 90) t = $urandom_range(BYTES - 40, BYTES + 40);
            else             t = $urandom;
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 9) == 0, t);
        end

        @(negedge clk);
        cmp("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
